kc705_ethernet_rgmii_axi_tx_arbiter: RTL
========================================

KC705_ETHERNET_RGMII_AXI_TX_ARBITER -- requirements
Module: kc705_ethernet_rgmii_axi_tx_arbiter

Interface
REQ-001 The block SHALL have parameter IFG_CYCLES, default 16'd12, meaning idle cycles forced between granted packets.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd1024, meaning consecutive source-stall cycles mid-packet before abort.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: axi_tclk  in  1  clock; axi_treset  in  1  synchronous active-high reset.
REQ-004 Ports SHALL be: enable_tx_arb  in  1  permits new grants.
REQ-005 Ports SHALL be: s0_tdata/s0_tvalid/s0_tlast  in  8/1/1  rx decoder response stream; s0_tready  out  1.
REQ-006 Ports SHALL be: s1_tdata/s1_tvalid/s1_tlast  in  8/1/1  packetizer ADC stream; s1_tready  out  1.
REQ-007 Ports SHALL be: tdata/tvalid/tlast/tuser  out  8/1/1/1  to TX datapath (tuser = aborted packet); tready  in  1.
REQ-008 Ports SHALL be: active_port  out  2  (2'b00 none, 2'b01 s0, 2'b10 s1); pkt_count0, pkt_count1, abort_count  out  16 each.

Function
REQ-009 The controller SHALL be a state machine with states IDLE, GRANT0, GRANT1, GAP.
REQ-010 Output tdata/tvalid/tlast/tuser SHALL be registered; latency from accepted input beat to tvalid SHALL be 1 cycle.
REQ-011 sX_tready SHALL equal (state==GRANTX) & (~tvalid | tready); all other ready outputs 0.
REQ-012 Output register SHALL load on sX_tvalid & sX_tready, hold while tvalid & ~tready, and clear tvalid on tready with no new load.
REQ-013 In IDLE with enable_tx_arb=1: only s0_tvalid -> GRANT0; only s1_tvalid -> GRANT1; both -> grant port not last served (round-robin).
REQ-014 In IDLE with enable_tx_arb=0 no grant SHALL be issued; deassertion during GRANTX SHALL NOT interrupt the packet.
REQ-015 Accepted beat with sX_tlast=1 SHALL set last_served=X, increment pkt_countX (16-bit wrap 0xFFFF->0), enter GAP, or IDLE when IFG_CYCLES=0.
REQ-016 GAP SHALL last exactly IFG_CYCLES cycles (counted from entry), then IDLE; inputs SHALL be ignored in GAP.
REQ-017 In GRANTX, stall counter SHALL increment each cycle sX_tvalid=0 and clear on sX_tvalid=1; output back-pressure SHALL NOT advance it.
REQ-018 When stall counter reaches TIMEOUT_CYCLES, the block SHALL emit one beat tdata=8'h00, tlast=1, tuser=1 (when output register free), increment abort_count (wrap), set last_served=X, enter GAP.
REQ-019 Source beats following an abort SHALL be treated as a new packet at next grant.
REQ-020 active_port SHALL reflect GRANT0/GRANT1, else 2'b00.
REQ-021 tuser SHALL be 0 on all non-abort beats.

Reset
REQ-022 On axi_treset=1 at a axi_tclk edge: state=IDLE, tvalid=0, tlast=0, tuser=0, tdata=8'h00, s0_tready=s1_tready=0, active_port=2'b00, all counters 0, stall/gap counters 0, last_served=1 (s0 wins first tie).
REQ-023 Reset mid-packet SHALL discard the partial packet with no abort beat and no counter increment.

Verification
REQ-024 Both sources present 64-byte packets continuously, tready=1 -> packets alternate s0,s1,s0,...; tvalid low exactly 12 cycles between each tlast and next first byte; pkt_count0=pkt_count1 after each pair.
REQ-025 s1 only, tready toggled 1/0 each cycle during 500-byte packet -> output bytes identical and in order, no duplicates/drops, tlast on byte 500 only.
REQ-026 s0 stops tvalid after byte 10 for 1024 cycles -> one beat tdata=00, tlast=1, tuser=1; abort_count=1; s1 granted after gap if valid.
REQ-027 enable_tx_arb=0 with both valid -> all ready 0, active_port=00; drop enable mid-packet -> packet completes, no new grant.
REQ-028 Assert axi_treset at byte 30 of a packet -> next cycle tvalid=0, counters 0; after release, first tie granted to s0.
REQ-029 Drive 65536 packets on s0 -> pkt_count0 wraps to 16'h0000.

Source files
------------

// File: rtl/kc705_ethernet_rgmii_axi_tx_arbiter.sv
// Two-source AXI-Stream packet arbiter for the KC705 RGMII TX path: round-robin
// grants on packet boundaries, an enforced inter-frame gap, and mid-packet stall abort.
module kc705_ethernet_rgmii_axi_tx_arbiter #(
  parameter logic [15:0] IFG_CYCLES     = 16'd12,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        axi_tclk,
  input  logic        axi_treset,
  input  logic        enable_tx_arb,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  output logic        s0_tready,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  output logic        s1_tready,
  output logic [7:0]  tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        tuser,
  input  logic        tready,
  output logic [1:0]  active_port,
  output logic [15:0] pkt_count0,
  output logic [15:0] pkt_count1,
  output logic [15:0] abort_count
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  // With fewer than two gap cycles the IDLE/grant setup already covers the gap.
  localparam bit USE_GAP = (IFG_CYCLES >= 16'd2);

  state_t      state, state_nxt;
  logic        last_served;
  logic [15:0] stall_cnt;
  logic [15:0] gap_cnt;

  logic [7:0]  data_p0;
  logic        vld_p0;
  logic        last_p0;
  logic        user_p0;

  logic        out_free;
  logic        in_grant;
  logic        src_vld;
  logic        src_last;
  logic [7:0]  src_data;
  logic        accept;
  logic        end_pkt;
  logic        abort_now;
  logic        pkt_done;
  logic        gap_done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] x, input logic [15:0] lim);
    sat_inc16 = (x < lim) ? x + 16'd1 : x;
  endfunction

  assign out_free  = ~vld_p0 | tready;
  assign in_grant  = (state == GRANT0) | (state == GRANT1);
  assign s0_tready = (state == GRANT0) & out_free;
  assign s1_tready = (state == GRANT1) & out_free;
  assign src_vld   = (state == GRANT1) ? s1_tvalid : s0_tvalid;
  assign src_last  = (state == GRANT1) ? s1_tlast  : s0_tlast;
  assign src_data  = (state == GRANT1) ? s1_tdata  : s0_tdata;
  assign accept    = in_grant & src_vld & out_free;
  assign end_pkt   = accept & src_last;
  // A source beat arriving on the timeout cycle wins over the abort.
  assign abort_now = in_grant & ~src_vld & out_free & (stall_cnt >= TIMEOUT_CYCLES);
  assign pkt_done  = end_pkt | abort_now;
  // The final tlast beat occupies the first GAP cycle and IDLE plus the grant
  // setup cycle follow, so the output sees exactly IFG_CYCLES idle cycles.
  assign gap_done  = (gap_cnt >= IFG_CYCLES - 16'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable_tx_arb) begin
          if (s0_tvalid && (!s1_tvalid || last_served)) state_nxt = GRANT0;
          else if (s1_tvalid)                           state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (pkt_done) begin
          if (USE_GAP) state_nxt = GAP;
          else         state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      last_served <= 1'b1;
      stall_cnt   <= '0;
      gap_cnt     <= '0;
      pkt_count0  <= '0;
      pkt_count1  <= '0;
      abort_count <= '0;
    end else begin
      if (pkt_done) last_served <= (state == GRANT1);
      if (end_pkt && state == GRANT0) pkt_count0 <= pkt_count0 + 16'd1;
      if (end_pkt && state == GRANT1) pkt_count1 <= pkt_count1 + 16'd1;
      if (abort_now) abort_count <= abort_count + 16'd1;

      if (in_grant && !pkt_done) begin
        if (src_vld) stall_cnt <= '0;
        else         stall_cnt <= sat_inc16(stall_cnt, TIMEOUT_CYCLES);
      end else begin
        stall_cnt <= '0;
      end

      if (state == GAP) gap_cnt <= gap_cnt + 16'd1;
      else              gap_cnt <= '0;
    end
  end

  // Output stage p0: one-deep register toward the TX datapath
  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      user_p0 <= 1'b0;
    end else if (accept) begin
      data_p0 <= src_data;
      vld_p0  <= 1'b1;
      last_p0 <= src_last;
      user_p0 <= 1'b0;
    end else if (abort_now) begin
      data_p0 <= 8'h00;
      vld_p0  <= 1'b1;
      last_p0 <= 1'b1;
      user_p0 <= 1'b1;
    end else if (tready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign tdata  = data_p0;
  assign tvalid = vld_p0;
  assign tlast  = last_p0;
  assign tuser  = user_p0;

  always_comb begin
    active_port = 2'b00;
    if (state == GRANT0) active_port = 2'b01;
    if (state == GRANT1) active_port = 2'b10;
  end

endmodule
